// File: rtl/step_scheduler.sv
// rtl/step_scheduler.sv - step index scheduler for the 8-step four-channel light-pattern datapath
//
// Purpose: owns the step index and paces it with a clock prescaler and a
// programmable per-step dwell. Supports free-run, hold and single-step
// control, and registers the pattern codes of the current step.
// Optional feature macro: STEP_SCHEDULER_REVERSE_EN (adds dir, reverse stepping).
//
// Ports:
//   ck        in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   run       in   level, 1 selects free-running stepping
//   step_req  in   single-step request, rising edge used only while idle
//   dwell     in   [3:0] ticks per step, 0 treated as 1
//   dir       in   (STEP_SCHEDULER_REVERSE_EN only) 1 selects reverse stepping
//   step      out  [2:0] current step index
//   data1..4  out  [2:0] pattern codes for the current step
//   wrap      out  one-cycle pulse when the step index wraps
//   busy      out  1 while free-running
module step_scheduler #(
   parameter int PRESCALE = 4
) (
   input  logic       ck,
   input  logic       reset,
   input  logic       run,
   input  logic       step_req,
   input  logic [3:0] dwell,
`ifdef STEP_SCHEDULER_REVERSE_EN
   input  logic       dir,
`endif
   output logic [2:0] step,
   output logic [2:0] data1,
   output logic [2:0] data2,
   output logic [2:0] data3,
   output logic [2:0] data4,
   output logic       wrap,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2
   } state_t;

   localparam logic [7:0] PC_LAST = 8'(PRESCALE - 1);

   state_t      r_state;
   logic [7:0]  r_pc;
   logic [3:0]  r_dc;
   logic        r_req_d;

   logic        w_req_edge;
   logic        w_tick;
   logic [3:0]  w_dwell_eff;
   logic        w_dwell_done;
   logic        w_dir;
   logic [2:0]  w_next_step;
   logic        w_next_wrap;

   // Pattern table packed as {data1, data2, data3, data4}.
   function automatic logic [11:0] f_pattern(input logic [2:0] s);
      logic [11:0] p;
      case (s)
         3'd0:    p = {3'd0, 3'd6, 3'd6, 3'd3};
         3'd1:    p = {3'd0, 3'd5, 3'd6, 3'd2};
         3'd2:    p = {3'd0, 3'd4, 3'd6, 3'd1};
         3'd3:    p = {3'd1, 3'd4, 3'd2, 3'd1};
         3'd4:    p = {3'd6, 3'd4, 3'd3, 3'd1};
         3'd5:    p = {3'd6, 3'd5, 3'd3, 3'd2};
         3'd6:    p = {3'd6, 3'd6, 3'd3, 3'd3};
         default: p = {3'd5, 3'd6, 3'd4, 3'd3};
      endcase
      return p;
   endfunction

`ifdef STEP_SCHEDULER_REVERSE_EN
   assign w_dir = dir;
`else
   assign w_dir = 1'b0;
`endif

   assign w_req_edge   = step_req & ~r_req_d;
   assign w_tick       = (r_state == S_RUN) && (r_pc == PC_LAST);
   assign w_dwell_eff  = (dwell == 4'd0) ? 4'd1 : dwell;
   // >= rather than == so that lowering dwell mid-step advances at the next tick
   assign w_dwell_done = (r_dc >= (w_dwell_eff - 4'd1));
   assign w_next_step  = w_dir ? (step - 3'd1) : (step + 3'd1);
   assign w_next_wrap  = w_dir ? (step == 3'd0) : (step == 3'd7);

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= 8'd0;
         r_dc    <= 4'd0;
         r_req_d <= 1'b0;
         step    <= 3'd0;
         {data1, data2, data3, data4} <= {3'd0, 3'd6, 3'd6, 3'd3};
         wrap    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         r_req_d <= step_req;
         wrap    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_pc <= 8'd0;
               if (run) begin
                  // run wins over a coincident step request
                  r_state <= S_RUN;
                  busy    <= 1'b1;
                  r_dc    <= 4'd0;
               end else if (w_req_edge) begin
                  r_state <= S_STEP;
                  step    <= w_next_step;
                  {data1, data2, data3, data4} <= f_pattern(w_next_step);
                  wrap    <= w_next_wrap;
               end
            end
            S_STEP: begin
               r_state <= S_IDLE;
               r_pc    <= 8'd0;
            end
            S_RUN: begin
               if (!run) begin
                  // stopping wins over a coincident tick; step and data are kept
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                  r_pc    <= 8'd0;
                  r_dc    <= 4'd0;
               end else begin
                  r_pc <= w_tick ? 8'd0 : (r_pc + 8'd1);
                  if (w_tick) begin
                     if (w_dwell_done) begin
                        r_dc <= 4'd0;
                        step <= w_next_step;
                        {data1, data2, data3, data4} <= f_pattern(w_next_step);
                        wrap <= w_next_wrap;
                     end else begin
                        r_dc <= r_dc + 4'd1;
                     end
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               r_pc    <= 8'd0;
               r_dc    <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_step_scheduler.sv
// tb/tb_step_scheduler.sv - directed self-checking bench for step_scheduler
module tb_step_scheduler;

   logic       ck;
   logic       reset;
   logic       run;
   logic       step_req;
   logic [3:0] dwell;
   logic [2:0] step;
   logic [2:0] data1, data2, data3, data4;
   logic       wrap;
   logic       busy;
   logic [11:0] w_data;

   int checks = 0;
   int errors = 0;

   assign w_data = {data1, data2, data3, data4};

   step_scheduler #(.PRESCALE(4)) u_dut (
      .ck       (ck),
      .reset    (reset),
      .run      (run),
      .step_req (step_req),
      .dwell    (dwell),
`ifdef STEP_SCHEDULER_REVERSE_EN
      .dir      (1'b0),
`endif
      .step     (step),
      .data1    (data1),
      .data2    (data2),
      .data3    (data3),
      .data4    (data4),
      .wrap     (wrap),
      .busy     (busy)
   );

`ifdef STEP_SCHEDULER_REVERSE_EN
   logic       run_r;
   logic       dir_r;
   logic [2:0] step_r;
   logic [2:0] rd1, rd2, rd3, rd4;
   logic       wrap_r;
   logic       busy_r;

   step_scheduler #(.PRESCALE(1)) u_rev (
      .ck       (ck),
      .reset    (reset),
      .run      (run_r),
      .step_req (1'b0),
      .dwell    (4'd1),
      .dir      (dir_r),
      .step     (step_r),
      .data1    (rd1),
      .data2    (rd2),
      .data3    (rd3),
      .data4    (rd4),
      .wrap     (wrap_r),
      .busy     (busy_r)
   );
`endif

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // wait n rising edges, then settle 1 time unit past the last one
   task automatic cyc(input int n);
      repeat (n) @(posedge ck);
      #1;
   endtask

   function automatic logic [11:0] pat(input int a, input int b, input int c, input int d);
      return {3'(a), 3'(b), 3'(c), 3'(d)};
   endfunction

   initial begin
      reset    = 1'b1;
      run      = 1'b0;
      step_req = 1'b0;
      dwell    = 4'd2;
`ifdef STEP_SCHEDULER_REVERSE_EN
      run_r = 1'b0;
      dir_r = 1'b1;
`endif
      cyc(3);
      check("rst_step", 32'(step), 32'd0);
      check("rst_data", 32'(w_data), 32'(pat(0, 6, 6, 3)));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      reset = 1'b0;
      cyc(2);
      check("idle_after_rst", 32'(step), 32'd0);

      // free run, dwell 2: advance every 8 cycles
      run = 1'b1;
      cyc(1);
      check("fr_busy", 32'(busy), 32'd1);
      cyc(7);
      check("fr_e7", 32'(step), 32'd0);
      cyc(1);
      check("fr_e8", 32'(step), 32'd1);
      check("fr_e8_data", 32'(w_data), 32'(pat(0, 5, 6, 2)));
      cyc(8);
      check("fr_e16", 32'(step), 32'd2);
      cyc(8);
      check("fr_e24", 32'(step), 32'd3);
      check("fr_e24_data", 32'(w_data), 32'(pat(1, 4, 2, 1)));
      cyc(16);
      check("fr_e40", 32'(step), 32'd5);

      // asynchronous reset mid-run
      reset = 1'b1;
      #1;
      check("arst_step", 32'(step), 32'd0);
      check("arst_data", 32'(w_data), 32'(pat(0, 6, 6, 3)));
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_wrap", 32'(wrap), 32'd0);
      cyc(1);
      reset = 1'b0;
      run   = 1'b0;
      cyc(3);
      check("arst_idle_busy", 32'(busy), 32'd0);
      check("arst_idle_step", 32'(step), 32'd0);

      // wrap, dwell 1: advance every 4 cycles, 7->0 at edge 32
      dwell = 4'd1;
      run   = 1'b1;
      cyc(1);
      cyc(31);
      check("wr_e31_step", 32'(step), 32'd7);
      check("wr_e31_wrap", 32'(wrap), 32'd0);
      cyc(1);
      check("wr_e32_step", 32'(step), 32'd0);
      check("wr_e32_wrap", 32'(wrap), 32'd1);
      check("wr_e32_data", 32'(w_data), 32'(pat(0, 6, 6, 3)));
      cyc(1);
      check("wr_e33_wrap", 32'(wrap), 32'd0);
      run = 1'b0;
      cyc(1);
      check("wr_stop_busy", 32'(busy), 32'd0);
      check("wr_stop_step", 32'(step), 32'd0);

      // single steps, pulses spaced 3 cycles apart
      for (int i = 0; i < 3; i++) begin
         step_req = 1'b1;
         cyc(1);
         check("ss_step", 32'(step), 32'(i + 1));
         step_req = 1'b0;
         cyc(2);
      end
      check("ss_data3", 32'(w_data), 32'(pat(1, 4, 2, 1)));
      step_req = 1'b1;
      cyc(10);
      check("ss_hold", 32'(step), 32'd4);
      step_req = 1'b0;
      cyc(2);
      check("ss_hold_after", 32'(step), 32'd4);

      // run and step_req together: run wins, no extra advance
      dwell    = 4'd2;
      run      = 1'b1;
      step_req = 1'b1;
      cyc(1);
      check("pr_busy", 32'(busy), 32'd1);
      check("pr_step", 32'(step), 32'd4);
      step_req = 1'b0;
      cyc(5);
      // dc is now 1; stopping keeps step 4
      run = 1'b0;
      cyc(1);
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_step", 32'(step), 32'd4);
      cyc(3);
      check("stop_hold", 32'(step), 32'd4);

      // restart begins a full dwell
      run = 1'b1;
      cyc(1);
      cyc(7);
      check("rerun_e7", 32'(step), 32'd4);
      cyc(1);
      check("rerun_e8", 32'(step), 32'd5);
      check("rerun_e8_data", 32'(w_data), 32'(pat(6, 5, 3, 2)));
      // dwell 0 behaves as 1
      dwell = 4'd0;
      cyc(3);
      check("dw0_e11", 32'(step), 32'd5);
      cyc(1);
      check("dw0_e12", 32'(step), 32'd6);
      // lowering dwell below dc+1 advances at the next tick
      dwell = 4'd3;
      cyc(5);
      dwell = 4'd1;
      cyc(2);
      check("lower_e19", 32'(step), 32'd6);
      cyc(1);
      check("lower_e20", 32'(step), 32'd7);
      run = 1'b0;
      cyc(2);

`ifdef STEP_SCHEDULER_REVERSE_EN
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(1);
      run_r = 1'b1;
      cyc(1);
      check("rev_e0_step", 32'(step_r), 32'd0);
      cyc(1);
      check("rev_e1_step", 32'(step_r), 32'd7);
      check("rev_e1_wrap", 32'(wrap_r), 32'd1);
      cyc(1);
      check("rev_e2_step", 32'(step_r), 32'd6);
      check("rev_e2_wrap", 32'(wrap_r), 32'd0);
      check("rev_e2_data", 32'({rd1, rd2, rd3, rd4}), 32'(pat(6, 6, 3, 3)));
      run_r = 1'b0;
      cyc(2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
